// File: rtl/frame_writer.sv
// frame_writer -- burst write master draining a pixel FIFO into a framebuffer.
//
// Each burst emits one write command (start word address + length), followed
// by BURST data beats. Data is passed straight through from the pixel FIFO,
// and the last beat is marked. A wrapping frame offset counter tracks the
// next burst's position in the frame. frame_i restarts the frame at word 0.
//
// Parameters: WIDTH data width, BURST beats/burst (1..256), DEPTH words/frame
//   (multiple of BURST, <= 2^AW), AW address width, BASE address of word 0.
// Ports:
//   clk_i, srst_ni                 clock, synchronous active-low reset
//   en_i, frame_i                  burst start enable, frame restart pulse
//   in_val_i/in_data_i/in_rdy_o    upstream pixel stream
//   cmd_val_o/cmd_addr_o/cmd_len_o/cmd_rdy_i   write command channel
//   wr_val_o/wr_data_o/wr_last_o/wr_rdy_i      write data channel
//   busy_o                         burst in progress
//   stat_bursts_o, stat_wrap_o     burst count / wrap pulse
// Optional feature macro: FRAME_WRITER_STATS_EN builds the statistics
// counters. Without it, the stat ports are tied to 0.
module frame_writer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned BURST = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 20,
  parameter int unsigned BASE  = 0
) (
  input  logic             clk_i,
  input  logic             srst_ni,
  input  logic             en_i,
  input  logic             frame_i,
  input  logic             in_val_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic             cmd_val_o,
  output logic [AW-1:0]    cmd_addr_o,
  output logic [7:0]       cmd_len_o,
  input  logic             cmd_rdy_i,
  output logic             wr_val_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             wr_last_o,
  input  logic             wr_rdy_i,
  output logic             busy_o,
  output logic [15:0]      stat_bursts_o,
  output logic             stat_wrap_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [AW-1:0] BASE_A    = AW'(BASE);
  localparam logic [AW-1:0] BURST_A   = AW'(BURST);
  // DEPTH == 2^AW truncates to 0, which still matches the wrapped AW-bit sum.
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [7:0]    LAST_BEAT = 8'(BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [7:0]    beat_q, beat_d;
  logic          pend_q, pend_d;

  logic [AW-1:0] offset_sum;
  logic          at_end;
  logic          last_hs;

  assign offset_sum = offset_q + BURST_A;
  assign at_end     = (offset_sum == DEPTH_A);
  assign last_hs    = (state_q == S_DATA) && in_val_i && wr_rdy_i && (beat_q == LAST_BEAT);

  assign cmd_addr_o = BASE_A + offset_q;
  assign cmd_len_o  = LAST_BEAT;
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    beat_d    = beat_q;
    pend_d    = pend_q;
    cmd_val_o = 1'b0;
    in_rdy_o  = 1'b0;
    wr_val_o  = 1'b0;
    wr_data_o = '0;
    wr_last_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Clearing here lets a frame pulse coincident with the start
        // transition place this very burst at word 0.
        if (frame_i) offset_d = '0;
        if (en_i && in_val_i) state_d = S_CMD;
      end
      S_CMD: begin
        cmd_val_o = 1'b1;
        if (frame_i) pend_d = 1'b1;
        if (cmd_rdy_i) state_d = S_DATA;
      end
      S_DATA: begin
        wr_val_o  = in_val_i;
        in_rdy_o  = wr_rdy_i;
        wr_data_o = in_data_i;
        wr_last_o = in_val_i && (beat_q == LAST_BEAT);
        if (frame_i) pend_d = 1'b1;
        if (in_val_i && wr_rdy_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_IDLE;
            pend_d  = 1'b0;
            // A frame pulse landing on the final beat counts as pending too.
            if (pend_q || frame_i) offset_d = '0;
            else if (at_end)       offset_d = '0;
            else                   offset_d = offset_sum;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      beat_q   <= beat_d;
      pend_q   <= pend_d;
    end
  end

`ifdef FRAME_WRITER_STATS_EN
  logic [15:0] bursts_q, bursts_d;
  logic        wrap_q, wrap_d;

  always_comb begin
    bursts_d = bursts_q;
    if (last_hs && (bursts_q != 16'hFFFF)) bursts_d = bursts_q + 16'd1;
    // Only a natural wrap counts; a frame restart is not a wrap.
    wrap_d = last_hs && !(pend_q || frame_i) && at_end;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      bursts_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      bursts_q <= bursts_d;
      wrap_q   <= wrap_d;
    end
  end

  assign stat_bursts_o = bursts_q;
  assign stat_wrap_o   = wrap_q;
`else
  assign stat_bursts_o = '0;
  assign stat_wrap_o   = 1'b0;
`endif

endmodule

// File: doc/frame_writer.md
# frame_writer

Burst write master at the consumer end of a burst-mode FIFO. It drains a valid/ready pixel stream in fixed-length bursts and issues one write command per burst (word address plus length), followed by the burst's data beats with a last marker. It maintains a wrapping frame address counter and sits between the pixel FIFO and the framebuffer memory write port.

## Interface
- WIDTH, 24, data word width.
- BURST, 16, beats per burst; legal range 1..256.
- DEPTH, 1024, words per frame; must be a multiple of BURST.
- AW, 20, address width; DEPTH must be at most 2^AW.
- BASE, 0, word address of frame word 0.

- clk_i  in  1  clock; everything runs on the rising edge.
- srst_ni  in  1  synchronous reset, active low.
- en_i  in  1  permits new bursts to start.
- frame_i  in  1  one-cycle pulse: the next burst starts at frame word 0.
- in_val_i  in  1  upstream valid; asserted only when at least BURST words are available.
- in_data_i  in  WIDTH  upstream data.
- in_rdy_o  out  1  upstream ready.
- cmd_val_o  out  1  write command valid.
- cmd_addr_o  out  AW  burst start word address, equal to BASE + offset.
- cmd_len_o  out  8  BURST-1.
- cmd_rdy_i  in  1  write command accepted.
- wr_val_o  out  1  write data valid.
- wr_data_o  out  WIDTH  write data.
- wr_last_o  out  1  final beat of the burst.
- wr_rdy_i  in  1  write data accepted.
- busy_o  out  1  high in CMD or DATA.

## Operation
- FSM states: IDLE, CMD, DATA.
- IDLE → CMD when en_i && in_val_i.
- CMD: cmd_val_o=1. Move to DATA on cmd_rdy_i.
- DATA:
  - wr_val_o = in_val_i, in_rdy_o = wr_rdy_i, wr_data_o = in_data_i (combinational passthrough).
  - Beat counter counts handshakes 0..BURST-1. wr_last_o = wr_val_o && (beat == BURST-1).
  - On the last handshake: beat clears, offset advances by BURST, state returns to IDLE.
- In all other states, in_rdy_o, wr_val_o and wr_last_o are 0.
- Offset: when offset + BURST == DEPTH, it wraps to 0. Arithmetic is AW bits; cmd_addr_o = BASE + offset, truncated to AW bits.
- frame_i:
  - In IDLE, it clears offset in the same cycle.
  - In CMD or DATA, it sets a pending flag. At burst end, the pending flag makes offset 0 instead of the advanced value, then the flag clears.
  - frame_i in the same cycle as the IDLE→CMD transition: the command uses offset 0.
- en_i low blocks only the IDLE→CMD transition. A burst already started always completes.
- cmd_addr_o and cmd_len_o are held stable while cmd_val_o is high.

## Timing
- Reset (srst_ni=0 at a clock edge):
  - State IDLE; offset, beat, pending flag and stats cleared.
  - All outputs 0 except cmd_len_o (constant) and cmd_addr_o = BASE.
- Reset mid-burst abandons the burst. Downstream must be reset alongside.
- in_val_i sampled high in IDLE at edge n gives cmd_val_o high from cycle n+1.
- A command accepted at edge m enables data from cycle m+1. Data latency is zero cycles.
- Minimum burst period is BURST+2 cycles: one IDLE cycle, one CMD cycle, BURST data cycles.
- Stalls: wr_rdy_i=0 or in_val_i=0 in DATA holds the beat count unchanged.

## Configuration
- FRAME_WRITER_STATS_EN defined:
  - Adds output stat_bursts_o [15:0], a saturating count of completed bursts, cleared by reset.
  - Adds output stat_wrap_o, a one-cycle pulse when offset wraps to 0 by reaching DEPTH (not when cleared by frame_i).
- Undefined: both ports still exist, tied to 0, and no counter logic is built.

## Test plan
- BURST=4, DEPTH=16, BASE=0x100; upstream always valid with data 0,1,2,…; both ready inputs held 1 → commands at 0x100, 0x104, 0x108, 0x10C, 0x100. wr_last_o on data 3, 7, 11, 15. stat_wrap_o pulses after the 4th burst.
- cmd_rdy_i held 0 for 5 cycles → cmd_val_o and cmd_addr_o held stable. in_rdy_o and wr_val_o stay 0 until acceptance.
- wr_rdy_i toggled 1,0,1,0 in DATA → exactly 4 handshakes with data passed in order. wr_last_o asserts only with the 4th handshake.
- frame_i pulsed during beat 2 of the burst at 0x104 → the burst completes, and the next command is at 0x100, not 0x108.
- en_i dropped mid-burst → the burst finishes. With in_val_i=1, no new cmd_val_o appears until en_i returns; cmd_val_o rises the cycle after en_i is sampled high.
- srst_ni=0 during DATA beat 1 → next cycle all outputs are 0, busy_o=0, cmd_addr_o=BASE. The following burst starts at BASE.
